dds_phaser_core: RTL and testbench
==================================

Name: dds_phaser_core

Overview:
- Direct digital synthesizer (DDS) that produces a 12-bit sine sample every clock.
- A 16-bit phase accumulator, advanced by a programmable frequency tuning word (FTW) and shifted by a programmable phase offset word (POW), addresses a quarter-wave sine ROM.
- FTW and POW are set through a simple write-only register port from the host/control logic.
- Output is offset-binary, intended for a DAC or downstream mixing logic.

Parameters:
- DW, 12, output sample width (fixed; ROM contents are defined for 12 bits).
- AW, 16, register address and data width.
- FTW_ADDR, 16'h0020, address of the frequency tuning word register.
- POW_ADDR, 16'h0030, address of the phase offset word register.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- wr  input  1  register write strobe, one cycle per write.
- waddr  input  16  register write address.
- wdata  input  16  register write data.
- out_valid  output  1  high when dout carries a valid pipelined sample.
- dout  output  12  sine sample, offset binary (mid-scale 0x800).

Behaviour:
- Reset (rstn=0, asynchronous), all registers cleared:
  - ftw=0, pow=0, acc=0, all pipeline registers 0.
  - dout=12'h800, out_valid=0.
- Register writes:
  - On a rising edge with wr=1: waddr==FTW_ADDR loads ftw<=wdata; waddr==POW_ADDR loads pow<=wdata.
  - Any other address is ignored. wr=0 changes nothing.
  - There is no readback.
- Stage 1, accumulator: every cycle, acc <= acc + ftw (16-bit, wraps modulo 2^16).
  - A new ftw written at edge E is first used at edge E+1.
- Stage 2, phase/ROM:
  - p = acc + pow (mod 2^16).
  - Quadrant q = p[15:14]; index i = p[13:8] (6 bits).
  - Register mag = ROM[i] when q is 0 or 2; mag = ROM[63-i] when q is 1 or 3.
  - Register neg = q[1].
- Stage 3, output: dout <= neg ? 2048 - mag : 2048 + mag. The range is 1..4095 and never overflows.
- ROM: 64 entries, 11 bits, ROM[k] = round(2047 * sin((2k+1)*pi/256)).
  - ROM[0]=25, ROM[63]=2047.
  - Monotonic increasing; implemented as a case table or initialized array.
- Latency:
  - acc to dout is 2 cycles.
  - An ftw/pow write takes effect on dout 3 edges after the write edge (pow: 2 edges).
- out_valid:
  - Rises on the 3rd rising edge after rstn deasserts, when the pipeline is filled, and stays high until reset.
  - Writes do not affect it.
- Frequency: f_out = f_clk * ftw / 65536.
  - ftw=0 gives a constant output of 12'h819 (ROM[0] above mid-scale).
- Phase resolution: only p[15:8] affects the output.
  - pow values below 0x100 have no visible effect at ftw=0.
- Simultaneous events:
  - A write in the same cycle as an accumulator update is fine; the accumulator uses the old ftw that cycle.
  - Back-to-back writes to the same address: the last one wins.
- Reset mid-operation: asynchronously returns every register to its reset value. ftw and pow must be reprogrammed.

Test Plan:
- Reset check: hold rstn=0 for 100 ns, then release.
  - dout=0x800 and out_valid=0 during reset.
  - out_valid=1 from the 3rd edge after release.
  - With ftw=0, dout settles to 0x819.
- POW write below ROM resolution: write POW=0x000F, then FTW=0x0002.
  - dout stays 0x819 until acc crosses 0x00F1. That is the point where (acc+pow)[15:8] becomes 1 (≈121 cycles after the FTW takes effect).
  - dout then steps to 2048+ROM[1]=2048+75=0x84B.
  - No other register changes.
- Full-speed sweep: write FTW=0x0100 from reset.
  - dout follows 2048±ROM over a 256-cycle period.
  - Peak 4095 at quadrant boundary 1, trough 1 at quadrant 3.
  - Waveform is symmetric; period is measured as exactly 256 clocks.
- Phase offset: with FTW=0, write POW=0x4000.
  - After 2 edges, dout=2048+ROM[63]=0xFFF.
  - With POW=0xC000, dout=2048-ROM[63]=0x001.
- Ignored address: wr=1 with waddr=0x0010 and arbitrary wdata.
  - dout and frequency are unchanged.
- Reset mid-operation: assert rstn low while FTW=0x0100 is running.
  - dout returns immediately to 0x800 and out_valid to 0.
  - After release, the output is constant 0x819 because ftw was cleared.

Source files
------------

// File: rtl/dds_phaser_core.sv
// 16-bit phase-accumulator DDS with a quarter-wave sine ROM.
// Emits one 12-bit offset-binary sample per clock through a three-stage pipeline.
module dds_phaser_core #(
  parameter int unsigned     DW       = 12,
  parameter int unsigned     AW       = 16,
  parameter logic [AW-1:0]   FTW_ADDR = 16'h0020,
  parameter logic [AW-1:0]   POW_ADDR = 16'h0030
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  output logic          out_valid,
  output logic [DW-1:0] dout
);

  logic [AW-1:0] ftw_q, ftw_d, pow_q, pow_d, acc_q, acc_d;
  logic [10:0]   mag_q, mag_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0]    fill_q, fill_d;
  logic [7:0]    phase_hi;
  logic [7:0]    phase_lo_unused;
  logic [5:0]    rom_idx;
  logic [10:0]   rom_val;

  always_comb begin
    ftw_d = ftw_q;
    pow_d = pow_q;
    if (wr) begin
      if (waddr == FTW_ADDR) ftw_d = wdata;
      if (waddr == POW_ADDR) pow_d = wdata;
    end
  end

  assign acc_d = acc_q + ftw_q;

  // Only the top byte of the phase addresses the ROM; the low byte only feeds the carry.
  assign {phase_hi, phase_lo_unused} = acc_q + pow_q;
  assign rom_idx = phase_hi[6] ? ~phase_hi[5:0] : phase_hi[5:0];
  assign mag_d   = rom_val;
  assign neg_d   = phase_hi[7];

  assign dout_d = neg_q ? (12'h800 - {1'b0, mag_q}) : (12'h800 + {1'b0, mag_q});
  assign fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;

  // round(2047 * sin((2k+1) * pi / 256)), k = 0..63
  always_comb begin
    rom_val = '0;
    case (rom_idx)
      6'd0:  rom_val = 11'd25;   6'd1:  rom_val = 11'd75;   6'd2:  rom_val = 11'd126;
      6'd3:  rom_val = 11'd176;  6'd4:  rom_val = 11'd226;  6'd5:  rom_val = 11'd275;
      6'd6:  rom_val = 11'd325;  6'd7:  rom_val = 11'd375;  6'd8:  rom_val = 11'd424;
      6'd9:  rom_val = 11'd473;  6'd10: rom_val = 11'd522;  6'd11: rom_val = 11'd570;
      6'd12: rom_val = 11'd618;  6'd13: rom_val = 11'd666;  6'd14: rom_val = 11'd713;
      6'd15: rom_val = 11'd760;  6'd16: rom_val = 11'd807;  6'd17: rom_val = 11'd852;
      6'd18: rom_val = 11'd898;  6'd19: rom_val = 11'd943;  6'd20: rom_val = 11'd987;
      6'd21: rom_val = 11'd1031; 6'd22: rom_val = 11'd1074; 6'd23: rom_val = 11'd1116;
      6'd24: rom_val = 11'd1158; 6'd25: rom_val = 11'd1199; 6'd26: rom_val = 11'd1239;
      6'd27: rom_val = 11'd1279; 6'd28: rom_val = 11'd1318; 6'd29: rom_val = 11'd1356;
      6'd30: rom_val = 11'd1393; 6'd31: rom_val = 11'd1430; 6'd32: rom_val = 11'd1465;
      6'd33: rom_val = 11'd1500; 6'd34: rom_val = 11'd1533; 6'd35: rom_val = 11'd1566;
      6'd36: rom_val = 11'd1598; 6'd37: rom_val = 11'd1629; 6'd38: rom_val = 11'd1659;
      6'd39: rom_val = 11'd1688; 6'd40: rom_val = 11'd1716; 6'd41: rom_val = 11'd1743;
      6'd42: rom_val = 11'd1769; 6'd43: rom_val = 11'd1793; 6'd44: rom_val = 11'd1817;
      6'd45: rom_val = 11'd1840; 6'd46: rom_val = 11'd1861; 6'd47: rom_val = 11'd1881;
      6'd48: rom_val = 11'd1901; 6'd49: rom_val = 11'd1919; 6'd50: rom_val = 11'd1936;
      6'd51: rom_val = 11'd1951; 6'd52: rom_val = 11'd1966; 6'd53: rom_val = 11'd1979;
      6'd54: rom_val = 11'd1992; 6'd55: rom_val = 11'd2003; 6'd56: rom_val = 11'd2012;
      6'd57: rom_val = 11'd2021; 6'd58: rom_val = 11'd2028; 6'd59: rom_val = 11'd2035;
      6'd60: rom_val = 11'd2039; 6'd61: rom_val = 11'd2043; 6'd62: rom_val = 11'd2046;
      6'd63: rom_val = 11'd2047;
      default: rom_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ftw_q  <= '0;
      pow_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      neg_q  <= 1'b0;
      dout_q <= 12'h800;
      fill_q <= '0;
    end else begin
      ftw_q  <= ftw_d;
      pow_q  <= pow_d;
      acc_q  <= acc_d;
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      dout_q <= dout_d;
      fill_q <= fill_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = (fill_q == 2'd3);

endmodule

// File: tb/tb_dds_phaser_core.sv
// Scoreboard bench for dds_phaser_core: a behavioural DDS model predicts each sample
// two edges ahead and feature tasks compare the DUT output against it.
module tb_dds_phaser_core;

  localparam logic [15:0] FtwAddr = 16'h0020;
  localparam logic [15:0] PowAddr = 16'h0030;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] waddr = '0;
  logic [15:0] wdata = '0;
  logic        out_valid;
  logic [11:0] dout;

  int checks_total = 0;
  int checks_passed = 0;

  logic [15:0] m_ftw, m_pow, m_acc;
  int          edges;
  logic [11:0] exp_q[$];
  logic [11:0] exp_dout;
  logic        exp_valid;

  dds_phaser_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .out_valid (out_valid),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  function automatic int rom_model(input int k);
    real x;
    x = 2047.0 * $sin((2.0 * k + 1.0) * 3.14159265358979 / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic logic [11:0] model_sample(input logic [15:0] acc, input logic [15:0] pow);
    logic [15:0] p;
    int i, m;
    p = acc + pow;
    i = int'(p[13:8]);
    if (p[14]) i = 63 - i;
    m = rom_model(i);
    return p[15] ? 12'(2048 - m) : 12'(2048 + m);
  endfunction

  task automatic model_reset();
    m_ftw = '0;
    m_pow = '0;
    m_acc = '0;
    edges = 0;
    exp_q.delete();
    exp_q.push_back(12'h800);
    exp_q.push_back(model_sample(16'h0, 16'h0));
  endtask

  // One clock: drive inputs, advance the model, leave sampling point 1 ns after the edge.
  task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wr = w;
    waddr = a;
    wdata = d;
    @(posedge clk);
    exp_dout = exp_q.pop_front();
    m_acc = m_acc + m_ftw;
    if (w && a == FtwAddr) m_ftw = d;
    if (w && a == PowAddr) m_pow = d;
    exp_q.push_back(model_sample(m_acc, m_pow));
    if (edges < 3) edges++;
    exp_valid = (edges >= 3);
    #1;
    wr = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #100;
    checks_total++;
    if (dout !== 12'h800) $display("FAIL reset_dout: got %h want 800", dout);
    else checks_passed++;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else checks_passed++;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    for (int n = 1; n <= 8; n++) begin
      drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL reset_fill_dout e%0d: got %h want %h", n, dout, exp_dout);
      else checks_passed++;
      checks_total++;
      if (out_valid !== exp_valid)
        $display("FAIL reset_fill_valid e%0d: got %b want %b", n, out_valid, exp_valid);
      else checks_passed++;
    end
    checks_total++;
    if (dout !== 12'h819) $display("FAIL reset_settle: got %h want 819", dout);
    else checks_passed++;
  endtask

  task automatic test_pow_fine();
    int first_step;
    first_step = -1;
    drive(1'b1, PowAddr, 16'h000F);
    drive(1'b1, FtwAddr, 16'h0002);
    for (int k = 1; k <= 140; k++) begin
      drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL pow_fine_dout k%0d: got %h want %h", k, dout, exp_dout);
      else checks_passed++;
      if (first_step < 0 && dout !== 12'h819) first_step = k;
    end
    checks_total++;
    if (first_step != 123) $display("FAIL pow_fine_step_cycle: got %0d want 123", first_step);
    else checks_passed++;
  endtask

  task automatic test_sweep();
    logic [11:0] smp [600];
    int last_peak, periods, vmax, vmin, bad;
    last_peak = -1;
    periods = 0;
    vmax = 0;
    vmin = 4096;
    bad = 0;
    reset_dut();
    drive(1'b1, FtwAddr, 16'h0100);
    for (int n = 0; n < 600; n++) begin
      // Unmapped address mid-sweep must leave frequency and phase alone.
      if (n == 300) drive(1'b1, 16'h0010, 16'hA5A5);
      else drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL sweep_dout n%0d: got %h want %h", n, dout, exp_dout);
      else checks_passed++;
      smp[n] = dout;
      if (int'(dout) > vmax) vmax = int'(dout);
      if (int'(dout) < vmin) vmin = int'(dout);
      if (n > 0 && dout == 12'hFFF && smp[n-1] != 12'hFFF) begin
        if (last_peak >= 0) begin
          checks_total++;
          if (n - last_peak != 256) $display("FAIL sweep_period: got %0d want 256", n - last_peak);
          else checks_passed++;
          periods++;
        end
        last_peak = n;
      end
    end
    for (int n = 10; n < 400; n++)
      if (int'(smp[n]) + int'(smp[n+128]) != 4096) bad++;
    checks_total++;
    if (vmax != 4095) $display("FAIL sweep_peak: got %0d want 4095", vmax);
    else checks_passed++;
    checks_total++;
    if (vmin != 1) $display("FAIL sweep_trough: got %0d want 1", vmin);
    else checks_passed++;
    checks_total++;
    if (periods < 2) $display("FAIL sweep_period_count: got %0d want >=2", periods);
    else checks_passed++;
    checks_total++;
    if (bad != 0) $display("FAIL sweep_symmetry: got %0d asymmetric pairs want 0", bad);
    else checks_passed++;
  endtask

  task automatic test_phase_offset();
    reset_dut();
    repeat (3) drive(1'b0, 16'h0, 16'h0);
    drive(1'b1, PowAddr, 16'h00FF);
    repeat (2) drive(1'b0, 16'h0, 16'h0);
    checks_total++;
    if (dout !== 12'h819) $display("FAIL pow_sub_lsb: got %h want 819", dout);
    else checks_passed++;
    drive(1'b1, PowAddr, 16'h4000);
    drive(1'b0, 16'h0, 16'h0);
    checks_total++;
    if (dout !== 12'h819) $display("FAIL pow_4000_e1: got %h want 819", dout);
    else checks_passed++;
    drive(1'b0, 16'h0, 16'h0);
    checks_total++;
    if (dout !== 12'hFFF) $display("FAIL pow_4000_e2: got %h want fff", dout);
    else checks_passed++;
    drive(1'b1, PowAddr, 16'hC000);
    repeat (2) drive(1'b0, 16'h0, 16'h0);
    checks_total++;
    if (dout !== 12'h001) $display("FAIL pow_c000_e2: got %h want 001", dout);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, PowAddr, 16'h4000);
    drive(1'b1, PowAddr, 16'hC000);
    drive(1'b1, FtwAddr, 16'h1234);
    drive(1'b1, FtwAddr, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL b2b_dout k%0d: got %h want %h", k, dout, exp_dout);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive(1'b1, FtwAddr, 16'h0100);
    for (int k = 0; k < 50; k++) begin
      drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL mid_run_dout k%0d: got %h want %h", k, dout, exp_dout);
      else checks_passed++;
    end
    #1;
    rstn = 1'b0;
    #1;
    checks_total++;
    if (dout !== 12'h800) $display("FAIL mid_reset_dout: got %h want 800", dout);
    else checks_passed++;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_valid);
    else checks_passed++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 16'h0, 16'h0);
      checks_total++;
      if (dout !== exp_dout) $display("FAIL mid_after_dout k%0d: got %h want %h", k, dout, exp_dout);
      else checks_passed++;
    end
    checks_total++;
    if (dout !== 12'h819) $display("FAIL mid_after_const: got %h want 819", dout);
    else checks_passed++;
    checks_total++;
    if (out_valid !== 1'b1) $display("FAIL mid_after_valid: got %b want 1", out_valid);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_pow_fine();
    test_sweep();
    test_phase_offset();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
